apurador_votos: RTL
===================

// Module: apurador_votos
// PURPOSE
//  Day-phase vote sequencer and tally. Enabled by the control unit's `votacao` level (DIA_VOTO).
//  Polls each living player in turn, takes one vote per player on `passa`, and tallies the votes.
//  Finds the player with the most votes and reports `votou` / `acertou` back to the control unit,
//  which then branches PROCESSA_VOTO -> LOBO_PERDEU or MATARAM_O_MARUITI.
// PARAMETERS
//  N_JOG   5  number of players (ids 0..N_JOG-1)
//  W_ID    3  player-id width; id 3'b111 = "none"
//  W_CNT   3  per-player tally width; must hold N_JOG without overflow
// PORTS
//  clock          in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  votacao        in   1      enable level from control unit; deassert = abort
//  passa          in   1      single-cycle confirm pulse (debounced button)
//  voto           in   W_ID   target id selected by the current voter
//  vivos          in   N_JOG  alive mask, bit i = player i alive
//  lobo_id        in   W_ID   id of the werewolf
//  jogador_atual  out  W_ID   id of the current voter; 3'b111 when not polling
//  votou          out  1      voting finished, result valid (level)
//  acertou        out  1      eliminated player == lobo_id (valid while votou)
//  empate         out  1      tie or no votes; nobody eliminated (valid while votou)
//  eliminado      out  W_ID   most-voted id, 3'b111 on tie/none
//  db_estado      out  3      current state encoding, for debug
// BEHAVIOUR
//  Reset values: state OCIOSO, tallies 0, jogador_atual=3'b111, votou=0, acertou=0,
//   empate=0, eliminado=3'b111.
//  States (encoding in db_estado):
//   OCIOSO(0):   votacao=1 -> CARREGA
//   CARREGA(1):  clear all tallies, idx=0 -> CHECA
//   CHECA(2):    vivos[idx] -> ESPERA; else idx==N_JOG-1 -> APURA; else idx++, stay CHECA
//   ESPERA(3):   jogador_atual=idx. passa & valid vote -> REGISTRA; otherwise stay
//   REGISTRA(4): tally[voto]++; idx==N_JOG-1 -> APURA; else idx++ -> CHECA
//   APURA(5):    scan ids 0..N_JOG-1, one per cycle (N_JOG cycles); track max and tie flag -> FIM
//   FIM(6):      votou=1; outputs held stable; votacao=0 -> OCIOSO
//  Valid vote: voto < N_JOG and vivos[voto]=1. Self-votes are allowed.
//   An invalid vote on passa is ignored: no tally change, state stays ESPERA.
//  Scan rule: a strictly greater tally replaces the current max and clears the tie flag.
//   An equal non-zero tally sets the tie flag.
//   Result: empate = tie | (max==0); eliminado = empate ? 3'b111 : argmax;
//   acertou = !empate & (eliminado==lobo_id).
//  Result outputs are registered; they update in the cycle FIM is entered and are 0/3'b111 in
//   every other state.
//  Latency: votou rises N_JOG+1 cycles after the final REGISTRA, plus one CHECA cycle per
//   trailing dead player.
//  Abort: votacao=0 in any state other than OCIOSO -> OCIOSO next cycle; partial tallies are
//   discarded. Abort takes priority over passa in the same cycle.
//  passa in any state other than ESPERA is ignored. The control unit's own passa&&votou
//   consumption in DIA_VOTO does not restart the vote, because FIM exits only on votacao=0.
//  vivos and lobo_id are sampled live. The control unit holds them stable during DIA_VOTO.
//  Tally increments saturate at 2^W_CNT-1 (unreachable with defaults).
//  Reset asserted mid-operation: immediate return to reset values.
// STRUCTURE
//  Shared package (polilobinho_pkg): N_JOG, W_ID, ID_NENHUM=3'b111, and the apurador state
//   encodings, so that the display/debug decoder can share them.
//  One sub-module: contador_votos (N_JOG saturating W_CNT counters with sync clear and indexed
//   increment). The FSM, index counter, and argmax scan live in apurador_votos.
// TESTING
//  1 All 5 alive, lobo_id=2, votes 2,2,1,2,0 -> votou=1, eliminado=2, empate=0, acertou=1.
//  2 All alive, lobo_id=4, votes 0,0,1,1,3 -> empate=1, eliminado=3'b111, acertou=0.
//  3 vivos=5'b10110, votes 4,1,4 -> ids 0 and 3 never shown in jogador_atual; eliminado=4.
//  4 In ESPERA, voto=3 with vivos[3]=0, then passa -> state stays ESPERA and tallies unchanged;
//    voto=7 -> also ignored.
//  5 votacao dropped after 2 votes, then raised again -> tallies cleared; the new vote counts
//    only fresh votes.
//  6 reset pulsed in APURA -> all outputs return to reset values asynchronously;
//    vivos=0 with votacao=1 -> empate=1, eliminado=3'b111.

Source files
------------

// File: rtl/polilobinho_pkg.sv
// rtl/polilobinho_pkg.sv - shared game constants and vote-sequencer state encodings
package polilobinho_pkg;

    localparam int N_JOG = 5;
    localparam int W_ID  = 3;
    localparam int W_CNT = 3;

    localparam logic [W_ID-1:0] ID_NENHUM = '1;
    localparam logic [W_ID-1:0] ID_ULTIMO = W_ID'(N_JOG - 1);
    localparam logic [W_ID-1:0] ID_LIMITE = W_ID'(N_JOG);

    // Encodings are exposed on db_estado and decoded by the debug display.
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CARREGA  = 3'd1,
        CHECA    = 3'd2,
        ESPERA   = 3'd3,
        REGISTRA = 3'd4,
        APURA    = 3'd5,
        FIM      = 3'd6
    } apurador_estado_t;

endpackage

// File: rtl/contador_votos.sv
// rtl/contador_votos.sv - per-player saturating vote tallies with sync clear and indexed increment
module contador_votos #(
    parameter int N     = 5,
    parameter int W_ID  = 3,
    parameter int W_CNT = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               incrementa,
    input  logic [W_ID-1:0]    alvo,
    output logic [N*W_CNT-1:0] contagens
);

    logic [W_CNT-1:0] cnt [N];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (limpa) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (incrementa) begin
            // Out-of-range targets match no counter and are dropped.
            for (int i = 0; i < N; i++) begin
                if (alvo == W_ID'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign contagens[g*W_CNT +: W_CNT] = cnt[g];
    end

endmodule

// File: rtl/apurador_votos.sv
// rtl/apurador_votos.sv - day-phase vote sequencer, tally and most-voted scan
module apurador_votos
    import polilobinho_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             votacao,
    input  logic             passa,
    input  logic [W_ID-1:0]  voto,
    input  logic [N_JOG-1:0] vivos,
    input  logic [W_ID-1:0]  lobo_id,
    output logic [W_ID-1:0]  jogador_atual,
    output logic             votou,
    output logic             acertou,
    output logic             empate,
    output logic [W_ID-1:0]  eliminado,
    output logic [2:0]       db_estado
);

    apurador_estado_t estado, prox_estado;

    logic [W_ID-1:0]        idx;
    logic [W_ID-1:0]        voto_reg;
    logic [W_ID-1:0]        scan;
    logic [W_ID-1:0]        arg_max;
    logic [W_CNT-1:0]       max_cnt;
    logic                   tie;
    logic                   limpa;
    logic                   incrementa;
    logic                   voto_valido;
    logic [N_JOG*W_CNT-1:0] contagens;
    logic [W_CNT-1:0]       tally_scan;
    logic [W_CNT-1:0]       max_nxt;
    logic [W_ID-1:0]        arg_nxt;
    logic                   tie_nxt;
    logic                   res_empate;
    logic [W_ID-1:0]        res_elim;
    logic                   res_acertou;

    contador_votos #(
        .N     (N_JOG),
        .W_ID  (W_ID),
        .W_CNT (W_CNT)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .limpa      (limpa),
        .incrementa (incrementa),
        .alvo       (voto_reg),
        .contagens  (contagens)
    );

    assign voto_valido = (voto < ID_LIMITE) && vivos[voto];
    assign tally_scan  = contagens[int'(scan)*W_CNT +: W_CNT];

    always_comb begin
        prox_estado = estado;
        limpa       = 1'b0;
        incrementa  = 1'b0;
        if (estado != OCIOSO && !votacao) begin
            prox_estado = OCIOSO;
        end else begin
            case (estado)
                OCIOSO:   if (votacao) prox_estado = CARREGA;
                CARREGA: begin
                    limpa       = 1'b1;
                    prox_estado = CHECA;
                end
                CHECA: begin
                    if (vivos[idx])            prox_estado = ESPERA;
                    else if (idx == ID_ULTIMO) prox_estado = APURA;
                end
                ESPERA:   if (passa && voto_valido) prox_estado = REGISTRA;
                REGISTRA: begin
                    incrementa  = 1'b1;
                    prox_estado = (idx == ID_ULTIMO) ? APURA : CHECA;
                end
                APURA:    if (scan == ID_ULTIMO) prox_estado = FIM;
                FIM:      prox_estado = FIM;
                default:  prox_estado = OCIOSO;
            endcase
        end
    end

    // First strictly greater tally wins; an equal non-zero tally marks a tie.
    always_comb begin
        max_nxt = max_cnt;
        arg_nxt = arg_max;
        tie_nxt = tie;
        if (tally_scan > max_cnt) begin
            max_nxt = tally_scan;
            arg_nxt = scan;
            tie_nxt = 1'b0;
        end else if (tally_scan == max_cnt && tally_scan != '0) begin
            tie_nxt = 1'b1;
        end
        res_empate  = tie_nxt | (max_nxt == '0);
        res_elim    = res_empate ? ID_NENHUM : arg_nxt;
        res_acertou = !res_empate && (res_elim == lobo_id);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            idx      <= '0;
            voto_reg <= '0;
            scan     <= '0;
            arg_max  <= ID_NENHUM;
            max_cnt  <= '0;
            tie      <= 1'b0;
        end else begin
            estado <= prox_estado;
            case (estado)
                CARREGA: begin
                    idx     <= '0;
                    scan    <= '0;
                    arg_max <= ID_NENHUM;
                    max_cnt <= '0;
                    tie     <= 1'b0;
                end
                CHECA:    if (prox_estado == CHECA) idx <= idx + W_ID'(1);
                ESPERA:   if (prox_estado == REGISTRA) voto_reg <= voto;
                REGISTRA: if (prox_estado == CHECA) idx <= idx + W_ID'(1);
                APURA: begin
                    scan    <= scan + W_ID'(1);
                    max_cnt <= max_nxt;
                    arg_max <= arg_nxt;
                    tie     <= tie_nxt;
                end
                default: ;
            endcase
        end
    end

    // Result is captured on FIM entry and held; every other state shows the idle values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            votou     <= 1'b0;
            acertou   <= 1'b0;
            empate    <= 1'b0;
            eliminado <= ID_NENHUM;
        end else if (estado == APURA && prox_estado == FIM) begin
            votou     <= 1'b1;
            acertou   <= res_acertou;
            empate    <= res_empate;
            eliminado <= res_elim;
        end else if (prox_estado != FIM) begin
            votou     <= 1'b0;
            acertou   <= 1'b0;
            empate    <= 1'b0;
            eliminado <= ID_NENHUM;
        end
    end

    assign jogador_atual = (estado == ESPERA) ? idx : ID_NENHUM;
    assign db_estado     = estado;

endmodule
